// File: rtl/pipe_pkg.sv
// Shared EX/MEM pipeline definitions: default widths, control-bit positions
// and the elastic-register state encoding.
package pipe_pkg;

    localparam int XLEN_DEFAULT = 32;
    localparam int RA_W_DEFAULT = 5;

    localparam int CTRL_W         = 4;
    localparam int CTRL_MEM_READ  = 3;
    localparam int CTRL_MEM_WRITE = 2;
    localparam int CTRL_REG_WRITE = 1;
    localparam int CTRL_MEM_TO_REG = 0;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_FULL  = 2'd1,
        ST_SKID  = 2'd2
    } state_e;

endpackage

// File: rtl/pipe_payload_reg.sv
// Purpose: width-parametrised enable-load payload register, synchronous clear.
// Latency: 1 cycle from load to q.
// Backpressure: none; the owner decides when to load.
module pipe_payload_reg #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= '0;
        end else if (load) begin
            q <= d;
        end
    end

endmodule

// File: rtl/ex_ma_elastic_reg.sv
// Purpose: EX->MEM pipeline register, valid/ready both sides, optional skid entry, flush.
// Latency: 1 cycle from accept to MA outputs.
// Backpressure: SKID=1 registered ready (no ma_ready_in comb path); SKID=0 pass-through ready.
module ex_ma_elastic_reg
    import pipe_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT,
    parameter int RA_W = RA_W_DEFAULT,
    parameter int SKID = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush_in,
    input  logic              ex_valid_in,
    output logic              ex_ready_out,
    input  logic [XLEN-1:0]   ex_pc_plus_4_in,
    input  logic [XLEN-1:0]   ex_alu_result_in,
    input  logic [XLEN-1:0]   ex_write_data_in,
    input  logic [RA_W-1:0]   ex_rd_addr_in,
    input  logic [CTRL_W-1:0] ex_ctrl_in,
    output logic              ma_valid_out,
    input  logic              ma_ready_in,
    output logic [XLEN-1:0]   ma_pc_plus_4_out,
    output logic [XLEN-1:0]   ma_alu_result_out,
    output logic [XLEN-1:0]   ma_write_data_out,
    output logic [RA_W-1:0]   ma_rd_addr_out,
    output logic [CTRL_W-1:0] ma_ctrl_out
);

    localparam int PAY_W = 3*XLEN + RA_W + CTRL_W;

    state_e              state_q, state_d;
    logic                accept, issue;
    logic                main_load, skid_load, main_from_skid;
    logic [CTRL_W-1:0]   ctrl_gated;
    logic [CTRL_W-1:0]   main_ctrl;
    logic [PAY_W-1:0]    in_pay, main_d, main_q, skid_q;

    // A write to x0 must never reach the register file.
    always_comb begin
        ctrl_gated = ex_ctrl_in;
        if (ex_rd_addr_in == '0) begin
            ctrl_gated[CTRL_REG_WRITE] = 1'b0;
        end
    end

    assign in_pay = {ex_pc_plus_4_in, ex_alu_result_in, ex_write_data_in, ex_rd_addr_in, ctrl_gated};
    assign main_d = main_from_skid ? skid_q : in_pay;

    assign ma_valid_out = (state_q != ST_EMPTY);
    assign accept       = ex_valid_in && ex_ready_out;
    assign issue        = ma_valid_out && ma_ready_in;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        main_load      = 1'b0;
        skid_load      = 1'b0;
        main_from_skid = 1'b0;
        if (flush_in) begin
            state_d = ST_EMPTY;
        end else begin
            unique case (state_q)
                ST_EMPTY: begin
                    if (accept) begin
                        state_d   = ST_FULL;
                        main_load = 1'b1;
                    end
                end
                ST_FULL: begin
                    if (accept && issue) begin
                        main_load = 1'b1;
                    end else if (accept && (SKID != 0)) begin
                        state_d   = ST_SKID;
                        skid_load = 1'b1;
                    end else if (issue) begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_SKID: begin
                    if (issue) begin
                        state_d        = ST_FULL;
                        main_load      = 1'b1;
                        main_from_skid = 1'b1;
                    end
                end
                default: state_d = ST_EMPTY;
            endcase
        end
    end

    generate
        if (SKID != 0) begin : g_skid_ready
            logic ready_q;
            always_ff @(posedge clk) begin
                if (rst) begin
                    ready_q <= 1'b1;
                end else begin
                    ready_q <= (state_d != ST_SKID);
                end
            end
            assign ex_ready_out = ready_q;
        end else begin : g_pass_ready
            assign ex_ready_out = !ma_valid_out || ma_ready_in;
        end
    endgenerate

    pipe_payload_reg #(.W(PAY_W)) u_main (
        .clk  (clk),
        .rst  (rst),
        .load (main_load),
        .d    (main_d),
        .q    (main_q)
    );

    pipe_payload_reg #(.W(PAY_W)) u_skid (
        .clk  (clk),
        .rst  (rst),
        .load (skid_load),
        .d    (in_pay),
        .q    (skid_q)
    );

    assign {ma_pc_plus_4_out, ma_alu_result_out, ma_write_data_out, ma_rd_addr_out, main_ctrl} = main_q;
    // Bubbles and flushed entries must not carry side-effect controls.
    assign ma_ctrl_out = ma_valid_out ? main_ctrl : '0;

endmodule

// File: tb/tb_ex_ma_elastic_reg.sv
// Scoreboarded bench for ex_ma_elastic_reg: instance a uses SKID=1, instance b uses SKID=0.
module tb_ex_ma_elastic_reg;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] alu;
        logic [31:0] wd;
        logic [4:0]  rd;
        logic [3:0]  ctrl;
    } exp_t;

    logic clk = 1'b0;
    logic rst;

    logic        flush_a, ev_a, er_a, mv_a, mr_a;
    logic [31:0] pc_a, alu_a, wd_a, opc_a, oalu_a, owd_a;
    logic [4:0]  rd_a, ord_a;
    logic [3:0]  ctl_a, octl_a;

    logic        flush_b, ev_b, er_b, mv_b, mr_b;
    logic [31:0] pc_b, alu_b, wd_b, opc_b, oalu_b, owd_b;
    logic [4:0]  rd_b, ord_b;
    logic [3:0]  ctl_b, octl_b;

    int   vectors = 0;
    int   miscompares = 0;
    exp_t q_a[$];
    exp_t q_b[$];

    always #5 clk = ~clk;

    ex_ma_elastic_reg #(.XLEN(32), .RA_W(5), .SKID(1)) dut_a (
        .clk(clk), .rst(rst), .flush_in(flush_a),
        .ex_valid_in(ev_a), .ex_ready_out(er_a),
        .ex_pc_plus_4_in(pc_a), .ex_alu_result_in(alu_a), .ex_write_data_in(wd_a),
        .ex_rd_addr_in(rd_a), .ex_ctrl_in(ctl_a),
        .ma_valid_out(mv_a), .ma_ready_in(mr_a),
        .ma_pc_plus_4_out(opc_a), .ma_alu_result_out(oalu_a), .ma_write_data_out(owd_a),
        .ma_rd_addr_out(ord_a), .ma_ctrl_out(octl_a)
    );

    ex_ma_elastic_reg #(.XLEN(32), .RA_W(5), .SKID(0)) dut_b (
        .clk(clk), .rst(rst), .flush_in(flush_b),
        .ex_valid_in(ev_b), .ex_ready_out(er_b),
        .ex_pc_plus_4_in(pc_b), .ex_alu_result_in(alu_b), .ex_write_data_in(wd_b),
        .ex_rd_addr_in(rd_b), .ex_ctrl_in(ctl_b),
        .ma_valid_out(mv_b), .ma_ready_in(mr_b),
        .ma_pc_plus_4_out(opc_b), .ma_alu_result_out(oalu_b), .ma_write_data_out(owd_b),
        .ma_rd_addr_out(ord_b), .ma_ctrl_out(octl_b)
    );

    // pc and store data are derived from alu so each vector is self-identifying.
    function automatic exp_t mk(input logic [31:0] alu, input logic [4:0] rd, input logic [3:0] ctrl);
        exp_t e;
        e.pc   = alu + 32'h0000_1000;
        e.alu  = alu;
        e.wd   = alu ^ 32'hFFFF_0000;
        e.rd   = rd;
        e.ctrl = ctrl;
        return e;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic cyc;
        @(posedge clk);
        #1;
    endtask

    task automatic drive_a(input logic v, input logic [31:0] alu, input logic [4:0] rd, input logic [3:0] ctrl);
        ev_a = v; alu_a = alu; pc_a = alu + 32'h0000_1000; wd_a = alu ^ 32'hFFFF_0000;
        rd_a = rd; ctl_a = ctrl;
    endtask

    task automatic drive_b(input logic v, input logic [31:0] alu, input logic [4:0] rd, input logic [3:0] ctrl);
        ev_b = v; alu_b = alu; pc_b = alu + 32'h0000_1000; wd_b = alu ^ 32'hFFFF_0000;
        rd_b = rd; ctl_b = ctrl;
    endtask

    always @(negedge clk) begin : mon_a
        exp_t got, e;
        if (!rst && mv_a && mr_a) begin
            got = {opc_a, oalu_a, owd_a, ord_a, octl_a};
            vectors++;
            if (q_a.size() == 0) begin
                miscompares++;
                $display("FAIL mon_a: unexpected issue alu=%h, nothing expected", oalu_a);
            end else begin
                e = q_a.pop_front();
                if (got !== e) begin
                    miscompares++;
                    $display("FAIL mon_a: got pc=%h alu=%h wd=%h rd=%h ctrl=%h expected pc=%h alu=%h wd=%h rd=%h ctrl=%h",
                             got.pc, got.alu, got.wd, got.rd, got.ctrl, e.pc, e.alu, e.wd, e.rd, e.ctrl);
                end
            end
        end
    end

    always @(negedge clk) begin : mon_b
        exp_t got, e;
        if (!rst && mv_b && mr_b) begin
            got = {opc_b, oalu_b, owd_b, ord_b, octl_b};
            vectors++;
            if (q_b.size() == 0) begin
                miscompares++;
                $display("FAIL mon_b: unexpected issue alu=%h, nothing expected", oalu_b);
            end else begin
                e = q_b.pop_front();
                if (got !== e) begin
                    miscompares++;
                    $display("FAIL mon_b: got pc=%h alu=%h wd=%h rd=%h ctrl=%h expected pc=%h alu=%h wd=%h rd=%h ctrl=%h",
                             got.pc, got.alu, got.wd, got.rd, got.ctrl, e.pc, e.alu, e.wd, e.rd, e.ctrl);
                end
            end
        end
    end

    initial begin
        // Reset for two cycles while EX offers an instruction.
        rst = 1'b1; flush_a = 1'b0; flush_b = 1'b0; mr_a = 1'b1; mr_b = 1'b0;
        drive_a(1'b1, 32'hDEAD, 5'd3, 4'b1111);
        drive_b(1'b0, 32'h0, 5'd0, 4'b0000);
        for (int i = 0; i < 2; i++) begin
            cyc;
            chk("rst_valid", 32'(mv_a), 32'd0);
            chk("rst_ctrl", 32'(octl_a), 32'd0);
            chk("rst_alu", oalu_a, 32'd0);
            chk("rst_pc", opc_a, 32'd0);
            chk("rst_rd", 32'(ord_a), 32'd0);
        end
        rst = 1'b0;
        drive_a(1'b0, 32'h0, 5'd0, 4'b0000);
        chk("rdy_after_rst_a", 32'(er_a), 32'd1);
        chk("rdy_after_rst_b", 32'(er_b), 32'd1);

        // Streaming with MEM always ready.
        drive_a(1'b1, 32'h10, 5'd1, 4'b1010); q_a.push_back(mk(32'h10, 5'd1, 4'b1010));
        cyc; chk("stream0_alu", oalu_a, 32'h10); chk("stream0_rdy", 32'(er_a), 32'd1);
        drive_a(1'b1, 32'h20, 5'd2, 4'b1001); q_a.push_back(mk(32'h20, 5'd2, 4'b1001));
        cyc; chk("stream1_alu", oalu_a, 32'h20); chk("stream1_rdy", 32'(er_a), 32'd1);
        drive_a(1'b1, 32'h30, 5'd3, 4'b0010); q_a.push_back(mk(32'h30, 5'd3, 4'b0010));
        cyc; chk("stream2_alu", oalu_a, 32'h30); chk("stream2_rdy", 32'(er_a), 32'd1);
        drive_a(1'b0, 32'h0, 5'd0, 4'b0000);
        cyc; chk("stream_drain_valid", 32'(mv_a), 32'd0);

        // Back-pressure into the skid entry.
        mr_a = 1'b0;
        drive_a(1'b1, 32'hA, 5'd4, 4'b1100); q_a.push_back(mk(32'hA, 5'd4, 4'b1100));
        cyc; chk("bp_full_alu", oalu_a, 32'hA); chk("bp_full_rdy", 32'(er_a), 32'd1);
        drive_a(1'b1, 32'hB, 5'd6, 4'b0011); q_a.push_back(mk(32'hB, 5'd6, 4'b0011));
        cyc; chk("bp_skid_alu", oalu_a, 32'hA); chk("bp_skid_rdy", 32'(er_a), 32'd0);
        drive_a(1'b0, 32'h0, 5'd0, 4'b0000);
        cyc; chk("bp_stable_alu", oalu_a, 32'hA); chk("bp_stable_pc", opc_a, 32'h100A);
        chk("bp_stable_ctrl", 32'(octl_a), 32'hC); chk("bp_stable_rdy", 32'(er_a), 32'd0);
        mr_a = 1'b1;
        cyc; chk("bp_rel_alu", oalu_a, 32'hB); chk("bp_rel_rdy", 32'(er_a), 32'd1);
        cyc; chk("bp_empty_valid", 32'(mv_a), 32'd0); chk("bp_empty_ctrl", 32'(octl_a), 32'd0);

        // Flush while in SKID, with a new instruction offered the same cycle.
        mr_a = 1'b0;
        drive_a(1'b1, 32'hA, 5'd4, 4'b1100); cyc;
        drive_a(1'b1, 32'hB, 5'd6, 4'b0011); cyc;
        chk("fl_pre_rdy", 32'(er_a), 32'd0);
        drive_a(1'b1, 32'hC, 5'd7, 4'b1010); flush_a = 1'b1;
        cyc;
        flush_a = 1'b0; drive_a(1'b0, 32'h0, 5'd0, 4'b0000);
        chk("fl_valid", 32'(mv_a), 32'd0); chk("fl_ctrl", 32'(octl_a), 32'd0);
        chk("fl_rdy", 32'(er_a), 32'd1);
        mr_a = 1'b1;
        cyc; cyc; chk("fl_after_valid", 32'(mv_a), 32'd0);

        // x0 write suppression.
        drive_a(1'b1, 32'h50, 5'd0, 4'b0010); q_a.push_back(mk(32'h50, 5'd0, 4'b0000));
        cyc; chk("x0_ctrl", 32'(octl_a), 32'h0);
        drive_a(1'b1, 32'h60, 5'd5, 4'b0010); q_a.push_back(mk(32'h60, 5'd5, 4'b0010));
        cyc; chk("rd5_ctrl", 32'(octl_a), 32'h2);
        drive_a(1'b1, 32'h70, 5'd0, 4'b1111); q_a.push_back(mk(32'h70, 5'd0, 4'b1101));
        cyc; chk("x0_other_bits", 32'(octl_a), 32'hD);
        drive_a(1'b0, 32'h0, 5'd0, 4'b0000);
        cyc; chk("x0_drain_valid", 32'(mv_a), 32'd0);

        // SKID=0 instance: pass-through ready with ma_ready_in toggling 1,0,1.
        mr_b = 1'b1;
        drive_b(1'b1, 32'h100, 5'd8, 4'b0010); q_b.push_back(mk(32'h100, 5'd8, 4'b0010));
        #1 chk("b_rdy_empty", 32'(er_b), 32'd1);
        cyc; chk("b_alu1", oalu_b, 32'h100);
        drive_b(1'b1, 32'h200, 5'd9, 4'b1000); q_b.push_back(mk(32'h200, 5'd9, 4'b1000));
        #1 chk("b_rdy_full_ready", 32'(er_b), 32'd1);
        cyc; chk("b_alu2", oalu_b, 32'h200);
        mr_b = 1'b0;
        drive_b(1'b1, 32'h300, 5'd10, 4'b0110);
        #1 chk("b_rdy_blocked", 32'(er_b), 32'd0);
        cyc; chk("b_hold_alu", oalu_b, 32'h200); chk("b_hold_valid", 32'(mv_b), 32'd1);
        mr_b = 1'b1; q_b.push_back(mk(32'h300, 5'd10, 4'b0110));
        #1 chk("b_rdy_release", 32'(er_b), 32'd1);
        cyc; chk("b_alu3", oalu_b, 32'h300);
        drive_b(1'b0, 32'h0, 5'd0, 4'b0000);
        cyc; chk("b_drain_valid", 32'(mv_b), 32'd0);

        for (int i = 0; i < 20 && (q_a.size() != 0 || q_b.size() != 0); i++) cyc;
        chk("queue_a_left", 32'(q_a.size()), 32'd0);
        chk("queue_b_left", 32'(q_b.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
